// File: rtl/lcd_pkg.sv
// Shared opcodes, constants and state type for the LCD bus capture block.
package lcd_pkg;

   localparam logic [7:0] CMD_CLEAR  = 8'h01;
   localparam logic [7:0] HOME_MASK  = 8'hFE;
   localparam logic [7:0] HOME_VAL   = 8'h02;
   localparam logic [7:0] ENTRY_MASK = 8'hFC;
   localparam logic [7:0] ENTRY_VAL  = 8'h04;
   localparam logic [7:0] DISP_MASK  = 8'hF8;
   localparam logic [7:0] DISP_VAL   = 8'h08;
   localparam logic [7:0] SHIFT_MASK = 8'hF0;
   localparam logic [7:0] SHIFT_VAL  = 8'h10;
   localparam logic [7:0] FUNC_MASK  = 8'hE0;
   localparam logic [7:0] FUNC_VAL   = 8'h20;
   localparam logic [7:0] CGRAM_MASK = 8'hC0;
   localparam logic [7:0] CGRAM_VAL  = 8'h40;
   localparam logic [7:0] DDRAM_MASK = 8'h80;
   localparam logic [7:0] DDRAM_VAL  = 8'h80;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [6:0] LINE0_BASE  = 7'h00;
   localparam logic [6:0] LINE1_BASE  = 7'h40;
   localparam logic [6:0] LINE_MASK   = 7'h70;
   localparam int         COLS        = 16;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } captState_e;

   function automatic logic isCmd(input logic [7:0] d, input logic [7:0] mask,
                                  input logic [7:0] val);
      return (d & mask) == val;
   endfunction

endpackage

// File: rtl/lcd_capture_edge_sync.sv
// Synchronizes the asynchronous LCD bus and flags the falling edge of E,
// presenting the RS/RW/DATA values that were valid while E was still high.
module lcd_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       lcdE,
   input  logic       lcdRs,
   input  logic       lcdRw,
   input  logic [7:0] lcdData,
   output logic       commit,
   output logic       heldRs,
   output logic       heldRw,
   output logic [7:0] heldData
);

   logic [10:0] sync_r [SYNC_STAGES];
   logic [10:0] prev_r;

   // Synchronizer chain plus one-cycle history for edge detection
   always_ff @(posedge CLK or posedge RESETN) begin
      if (RESETN) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 11'd0;
         prev_r <= 11'd0;
      end else begin
         sync_r[0] <= {lcdE, lcdRs, lcdRw, lcdData};
         for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign commit   = prev_r[10] & ~sync_r[SYNC_STAGES-1][10];
   assign heldRs   = prev_r[9];
   assign heldRw   = prev_r[8];
   assign heldData = prev_r[7:0];

endmodule

// File: rtl/lcd_bus_capture.sv
// Passive HD44780 bus decoder with a 2x16 shadow display RAM.
// Optional display-shift tracking is enabled with `define LCD_CAPTURE_SHIFT_EN.
module lcd_bus_capture
   import lcd_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CLEAR_CELLS = 32
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       LCD_E,
   input  logic       LCD_RS,
   input  logic       LCD_RW,
   input  logic [7:0] LCD_DATA,
   input  logic [4:0] RD_ADDR,
   output logic [7:0] RD_DATA,
   output logic [4:0] CURSOR,
   output logic       ADDR_VALID,
   output logic       DISP_ON,
   output logic       TWO_LINE,
   output logic       BUSY,
   output logic       WR_STB,
   output logic       ERR,
   output logic [7:0] DROP_CNT,
   output logic [3:0] SHIFT
);

   localparam logic [4:0] LAST_CELL = 5'(CLEAR_CELLS - 1);

   function automatic logic [4:0] stepCursor(input logic [4:0] cur, input logic inc);
      return inc ? cur + 5'd1 : cur - 5'd1;
   endfunction

   function automatic logic [7:0] satInc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic       commit_s, rs_s, rw_s;
   logic [7:0] data_s;

   lcd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
      .CLK      (CLK),
      .RESETN   (RESETN),
      .lcdE     (LCD_E),
      .lcdRs    (LCD_RS),
      .lcdRw    (LCD_RW),
      .lcdData  (LCD_DATA),
      .commit   (commit_s),
      .heldRs   (rs_s),
      .heldRw   (rw_s),
      .heldData (data_s)
   );

   captState_e state_r, stateNext;
   logic [7:0] cells_r [32];
   logic [4:0] cursor_r, cursorNext, clrIdx_r, clrIdxNext;
   logic       addrValid_r, addrValidNext, incr_r, incrNext;
   logic       dispOn_r, dispOnNext, twoLine_r, twoLineNext;
   logic       err_r, errNext, wrStb_r, wrStbNext, busy_r;
   logic [7:0] dropCnt_r, dropCntNext, rdData_r;
   logic       memWe;
   logic [4:0] memAddr, rdIdx_s;
   logic [7:0] memWdata;
`ifdef LCD_CAPTURE_SHIFT_EN
   logic [3:0] shift_r, shiftNext;
   logic       shiftEntry_r, shiftEntryNext;
`endif

   // Next-state, decode and memory-write control
   always_comb begin
      stateNext     = state_r;
      cursorNext    = cursor_r;
      clrIdxNext    = clrIdx_r;
      addrValidNext = addrValid_r;
      incrNext      = incr_r;
      dispOnNext    = dispOn_r;
      twoLineNext   = twoLine_r;
      errNext       = err_r;
      dropCntNext   = dropCnt_r;
      wrStbNext     = 1'b0;
      memWe         = 1'b0;
      memAddr       = 5'd0;
      memWdata      = ASCII_SPACE;
`ifdef LCD_CAPTURE_SHIFT_EN
      shiftNext      = shift_r;
      shiftEntryNext = shiftEntry_r;
`endif
      case (state_r)
         CLEAR: begin
            memWe   = 1'b1;
            memAddr = clrIdx_r;
            if (clrIdx_r == LAST_CELL) begin
               stateNext  = IDLE;
               cursorNext = 5'd0;
               incrNext   = 1'b1;
               clrIdxNext = 5'd0;
`ifdef LCD_CAPTURE_SHIFT_EN
               shiftNext  = 4'd0;
`endif
            end else begin
               clrIdxNext = clrIdx_r + 5'd1;
            end
            // Any write during the sweep is an error; a fresh clear restarts it
            if (commit_s && !rw_s) begin
               errNext = 1'b1;
               if (!rs_s && data_s == CMD_CLEAR) begin
                  stateNext  = CLEAR;
                  clrIdxNext = 5'd0;
               end else begin
                  dropCntNext = satInc(dropCnt_r);
               end
            end else begin
               errNext = err_r;
            end
         end
         IDLE: begin
            if (commit_s && !rw_s && rs_s) begin
               if (addrValid_r) begin
                  memWe      = 1'b1;
                  memAddr    = cursor_r;
                  memWdata   = data_s;
                  wrStbNext  = 1'b1;
                  cursorNext = stepCursor(cursor_r, incr_r);
`ifdef LCD_CAPTURE_SHIFT_EN
                  if (shiftEntry_r) shiftNext = incr_r ? shift_r - 4'd1 : shift_r + 4'd1;
                  else              shiftNext = shift_r;
`endif
               end else begin
                  dropCntNext = satInc(dropCnt_r);
               end
            end else if (commit_s && !rw_s) begin
               if (isCmd(data_s, DDRAM_MASK, DDRAM_VAL)) begin
                  if ((data_s[6:0] & LINE_MASK) == LINE0_BASE) begin
                     cursorNext    = data_s[4:0];
                     addrValidNext = 1'b1;
                  end else if ((data_s[6:0] & LINE_MASK) == LINE1_BASE) begin
                     cursorNext    = 5'(COLS) | {1'b0, data_s[3:0]};
                     addrValidNext = 1'b1;
                  end else begin
                     addrValidNext = 1'b0;
                     errNext       = 1'b1;
                  end
               end else if (isCmd(data_s, CGRAM_MASK, CGRAM_VAL)) begin
                  addrValidNext = 1'b0;
               end else if (isCmd(data_s, FUNC_MASK, FUNC_VAL)) begin
                  twoLineNext = data_s[3];
               end else if (isCmd(data_s, SHIFT_MASK, SHIFT_VAL)) begin
                  if (!data_s[3]) begin
                     cursorNext = stepCursor(cursor_r, data_s[2]);
                  end else begin
`ifdef LCD_CAPTURE_SHIFT_EN
                     shiftNext = data_s[2] ? shift_r + 4'd1 : shift_r - 4'd1;
`else
                     cursorNext = cursor_r;
`endif
                  end
               end else if (isCmd(data_s, DISP_MASK, DISP_VAL)) begin
                  dispOnNext = data_s[2];
               end else if (isCmd(data_s, ENTRY_MASK, ENTRY_VAL)) begin
                  incrNext = data_s[1];
`ifdef LCD_CAPTURE_SHIFT_EN
                  shiftEntryNext = data_s[0];
`endif
               end else if (isCmd(data_s, HOME_MASK, HOME_VAL)) begin
                  cursorNext    = 5'd0;
                  addrValidNext = 1'b1;
`ifdef LCD_CAPTURE_SHIFT_EN
                  shiftNext     = 4'd0;
`endif
               end else if (data_s == CMD_CLEAR) begin
                  stateNext  = CLEAR;
                  clrIdxNext = 5'd0;
               end else begin
                  stateNext = IDLE;
               end
            end else begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

`ifdef LCD_CAPTURE_SHIFT_EN
   assign rdIdx_s = {RD_ADDR[4], RD_ADDR[3:0] + shift_r};
`else
   assign rdIdx_s = RD_ADDR;
`endif

   // State and control registers
   always_ff @(posedge CLK or posedge RESETN) begin
      if (RESETN) begin
         state_r     <= IDLE;
         cursor_r    <= 5'd0;
         clrIdx_r    <= 5'd0;
         addrValid_r <= 1'b1;
         incr_r      <= 1'b1;
         dispOn_r    <= 1'b0;
         twoLine_r   <= 1'b0;
         err_r       <= 1'b0;
         dropCnt_r   <= 8'd0;
         wrStb_r     <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= stateNext;
         cursor_r    <= cursorNext;
         clrIdx_r    <= clrIdxNext;
         addrValid_r <= addrValidNext;
         incr_r      <= incrNext;
         dispOn_r    <= dispOnNext;
         twoLine_r   <= twoLineNext;
         err_r       <= errNext;
         dropCnt_r   <= dropCntNext;
         wrStb_r     <= wrStbNext;
         busy_r      <= (stateNext == CLEAR);
      end
   end

`ifdef LCD_CAPTURE_SHIFT_EN
   // Display shift window
   always_ff @(posedge CLK or posedge RESETN) begin
      if (RESETN) begin
         shift_r      <= 4'd0;
         shiftEntry_r <= 1'b0;
      end else begin
         shift_r      <= shiftNext;
         shiftEntry_r <= shiftEntryNext;
      end
   end
   assign SHIFT = shift_r;
`else
   assign SHIFT = 4'd0;
`endif

   // Shadow RAM with read-before-write registered read port
   always_ff @(posedge CLK or posedge RESETN) begin
      if (RESETN) begin
         for (int i = 0; i < 32; i++) cells_r[i] <= ASCII_SPACE;
         rdData_r <= ASCII_SPACE;
      end else begin
         if (memWe) cells_r[memAddr] <= memWdata;
         rdData_r <= cells_r[rdIdx_s];
      end
   end

   assign RD_DATA    = rdData_r;
   assign CURSOR     = cursor_r;
   assign ADDR_VALID = addrValid_r;
   assign DISP_ON    = dispOn_r;
   assign TWO_LINE   = twoLine_r;
   assign BUSY       = busy_r;
   assign WR_STB     = wrStb_r;
   assign ERR        = err_r;
   assign DROP_CNT   = dropCnt_r;

endmodule

// File: tb/tb_lcd_bus_capture.sv
// Directed self-checking bench for lcd_bus_capture.
module tb_lcd_bus_capture;

   logic       CLK = 1'b0;
   logic       RESETN = 1'b1;
   logic       LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
   logic [7:0] LCD_DATA = 8'h00;
   logic [4:0] RD_ADDR = 5'd0;
   logic [7:0] RD_DATA, DROP_CNT;
   logic [4:0] CURSOR;
   logic       ADDR_VALID, DISP_ON, TWO_LINE, BUSY, WR_STB, ERR;
   logic [3:0] SHIFT;

   int checks = 0;
   int errors = 0;
   int wrCount = 0, busyCount = 0, base = 0;
   logic [7:0] stbRd = 8'h00;

   lcd_bus_capture dut (
      .CLK(CLK), .RESETN(RESETN), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
      .LCD_DATA(LCD_DATA), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .CURSOR(CURSOR),
      .ADDR_VALID(ADDR_VALID), .DISP_ON(DISP_ON), .TWO_LINE(TWO_LINE), .BUSY(BUSY),
      .WR_STB(WR_STB), .ERR(ERR), .DROP_CNT(DROP_CNT), .SHIFT(SHIFT)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (WR_STB) wrCount <= wrCount + 1;
      if (BUSY) busyCount <= busyCount + 1;
   end

   always @(negedge CLK) if (WR_STB) stbRd <= RD_DATA;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic busWrite(input logic rs, input logic [7:0] d);
      @(negedge CLK);
      LCD_RS = rs; LCD_RW = 1'b0; LCD_DATA = d; LCD_E = 1'b1;
      repeat (3) @(negedge CLK);
      LCD_E = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic readCell(input string tag, input logic [4:0] a, input logic [7:0] exp);
      @(negedge CLK);
      RD_ADDR = a;
      @(negedge CLK);
      chk(tag, {24'd0, RD_DATA}, {24'd0, exp});
   endtask

   task automatic doReset();
      @(negedge CLK);
      LCD_E = 1'b0;
      RESETN = 1'b1;
      @(negedge CLK);
      RESETN = 1'b0;
      @(negedge CLK);
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      RESETN = 1'b0;
      @(negedge CLK);

      // Reset state
      chk("rst_rd_data", {24'd0, RD_DATA}, 32'h20);
      chk("rst_cursor", {27'd0, CURSOR}, 32'd0);
      chk("rst_addr_valid", {31'd0, ADDR_VALID}, 32'd1);
      chk("rst_flags", {26'd0, DISP_ON, TWO_LINE, BUSY, WR_STB, ERR, 1'b0}, 32'd0);
      chk("rst_drop", {24'd0, DROP_CNT}, 32'd0);
      chk("rst_shift", {28'd0, SHIFT}, 32'd0);

      // Init sequence and "HI"
      base = wrCount;
      busWrite(1'b0, 8'h3C);
      busWrite(1'b0, 8'h0C);
      busWrite(1'b0, 8'h06);
      busWrite(1'b1, 8'h48);
      busWrite(1'b1, 8'h49);
      chk("hi_two_line", {31'd0, TWO_LINE}, 32'd1);
      chk("hi_disp_on", {31'd0, DISP_ON}, 32'd1);
      chk("hi_cursor", {27'd0, CURSOR}, 32'd2);
      chk("hi_wr_stb", wrCount - base, 32'd2);
      readCell("hi_cell0", 5'd0, 8'h48);
      readCell("hi_cell1", 5'd1, 8'h49);

      // Second line then wrap 31->0
      busWrite(1'b0, 8'hC0);
      chk("l2_cursor", {27'd0, CURSOR}, 32'd16);
      for (int i = 0; i < 17; i++) busWrite(1'b1, 8'h41);
      chk("wrap_cursor", {27'd0, CURSOR}, 32'd1);
      readCell("wrap_cell16", 5'd16, 8'h41);
      readCell("wrap_cell31", 5'd31, 8'h41);
      readCell("wrap_cell0", 5'd0, 8'h41);
      readCell("wrap_cell1", 5'd1, 8'h49);
      chk("wrap_err", {31'd0, ERR}, 32'd0);

      // Clear with a data write landing mid-sweep
      base = busyCount;
      busWrite(1'b0, 8'h01);
      chk("clr_busy", {31'd0, BUSY}, 32'd1);
      busWrite(1'b1, 8'h5A);
      repeat (40) @(negedge CLK);
      chk("clr_busy_cycles", busyCount - base, 32'd32);
      chk("clr_busy_done", {31'd0, BUSY}, 32'd0);
      chk("clr_err", {31'd0, ERR}, 32'd1);
      chk("clr_drop", {24'd0, DROP_CNT}, 32'd1);
      chk("clr_cursor", {27'd0, CURSOR}, 32'd0);
      for (int i = 0; i < 32; i++) readCell("clr_cell", 5'(i), 8'h20);

      // Invalid DDRAM address drops following data
      doReset();
      base = wrCount;
      busWrite(1'b0, 8'h90);
      busWrite(1'b1, 8'h33);
      chk("bad_addr_valid", {31'd0, ADDR_VALID}, 32'd0);
      chk("bad_err", {31'd0, ERR}, 32'd1);
      chk("bad_drop", {24'd0, DROP_CNT}, 32'd1);
      chk("bad_no_stb", wrCount - base, 32'd0);
      readCell("bad_cell0", 5'd0, 8'h20);
      readCell("bad_cell16", 5'd16, 8'h20);

      // Decrement entry, 0->31 wrap, read-before-write
      doReset();
      busWrite(1'b0, 8'h04);
      RD_ADDR = 5'd0;
      busWrite(1'b1, 8'h31);
      chk("rbw_old", {24'd0, stbRd}, 32'h20);
      chk("rbw_new", {24'd0, RD_DATA}, 32'h31);
      chk("dec_cursor", {27'd0, CURSOR}, 32'd31);

      // Reset in the middle of a sweep
      doReset();
      busWrite(1'b0, 8'h3C);
      busWrite(1'b0, 8'h01);
      begin
         int n = 0;
         while (!BUSY && n < 20) begin @(negedge CLK); n++; end
         chk("mid_busy_seen", {31'd0, BUSY}, 32'd1);
      end
      repeat (9) @(negedge CLK);
      RESETN = 1'b1;
      @(negedge CLK);
      RESETN = 1'b0;
      chk("mid_busy", {31'd0, BUSY}, 32'd0);
      chk("mid_two_line", {31'd0, TWO_LINE}, 32'd0);
      chk("mid_cursor", {27'd0, CURSOR}, 32'd0);
      chk("mid_err_drop", {23'd0, ERR, DROP_CNT}, 32'd0);
      chk("mid_rd_data", {24'd0, RD_DATA}, 32'h20);
      repeat (3) @(negedge CLK);
      chk("mid_busy_later", {31'd0, BUSY}, 32'd0);

      // Display shift
      doReset();
      busWrite(1'b1, 8'h41);
      busWrite(1'b1, 8'h42);
      busWrite(1'b1, 8'h43);
      busWrite(1'b0, 8'h1C);
      busWrite(1'b0, 8'h1C);
      chk("shift_cursor", {27'd0, CURSOR}, 32'd3);
`ifdef LCD_CAPTURE_SHIFT_EN
      chk("shift_val", {28'd0, SHIFT}, 32'd2);
      readCell("shift_rd0", 5'd0, 8'h43);
`else
      chk("shift_val", {28'd0, SHIFT}, 32'd0);
      readCell("shift_rd0", 5'd0, 8'h41);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
